pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor.sv | 130 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and failure supervisor
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       lol_clr,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       fail,
    output logic [7:0] lol_count,
    output logic [7:0] retry_count,
    output logic [2:0] state
);

    localparam int RW = $clog2(PLL_RST_CYCLES) + 1;
    localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam logic [RW-1:0] RST_LAST    = RW'(PLL_RST_CYCLES);
    localparam logic [SW-1:0] STB_LAST    = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t                 cur_state;
    state_t                 nxt_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [RW-1:0]          rst_cnt;
    logic [SW-1:0]          stb_cnt;
    logic [TW-1:0]          tmo_cnt;
    logic                   lk;
    logic                   tmo_hit;
    logic                   lol_inc;
    logic                   pll_rst_d;
    logic                   sys_rst_n_d;
    logic                   fail_d;

    assign lk      = sync_q[SYNC_STAGES-1];
    assign tmo_hit = (cur_state == S_WAIT_LOCK) && !lk && (tmo_cnt == TMO_LAST);
    assign lol_inc = (cur_state == S_RUN) && !lk;
    assign state   = cur_state;

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_PLL_RESET: if (rst_cnt == RST_LAST) nxt_state = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                // a lock arriving on the timeout cycle takes priority
                if (lk)
                    nxt_state = S_STABLE;
                else if (tmo_hit)
                    nxt_state = (retry_count + 8'd1 == RETRY_LIMIT) ? S_FAIL : S_PLL_RESET;
            end
            S_STABLE: begin
                if (!lk)
                    nxt_state = S_WAIT_LOCK;
                else if (stb_cnt == STB_LAST)
                    nxt_state = S_RUN;
            end
            S_RUN:   if (!lk) nxt_state = S_PLL_RESET;
            S_FAIL:  nxt_state = S_FAIL;
            default: nxt_state = S_PLL_RESET;
        endcase
    end

    always_comb begin
        pll_rst_d   = 1'b0;
        sys_rst_n_d = 1'b0;
        fail_d      = 1'b0;
        case (nxt_state)
            S_PLL_RESET: pll_rst_d = 1'b1;
            S_RUN:       sys_rst_n_d = 1'b1;
            S_FAIL: begin
                pll_rst_d = 1'b1;
                fail_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            cur_state   <= S_PLL_RESET;
            sync_q      <= '0;
            rst_cnt     <= '0;
            stb_cnt     <= '0;
            tmo_cnt     <= '0;
            retry_count <= '0;
            lol_count   <= '0;
            pll_rst     <= 1'b1;
            sys_rst_n   <= 1'b0;
            fail        <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            pll_rst   <= pll_rst_d;
            sys_rst_n <= sys_rst_n_d;
            fail      <= fail_d;

            // Re-entry preloads 1 so the entering edge counts; after rst_n the
            // count starts at 0, giving PLL_RST_CYCLES full cycles after release.
            rst_cnt <= (cur_state == S_PLL_RESET) ? rst_cnt + RW'(1) : RW'(1);
            stb_cnt <= (cur_state == S_STABLE)    ? stb_cnt + SW'(1) : '0;
            tmo_cnt <= (cur_state == S_WAIT_LOCK) ? tmo_cnt + TW'(1) : '0;

            if (tmo_hit)
                retry_count <= retry_count + 8'd1;
            else if (cur_state == S_STABLE && nxt_state == S_RUN)
                retry_count <= '0;

            if (lol_clr)
                lol_count <= lol_inc ? 8'd1 : 8'd0;
            else if (lol_inc && lol_count != 8'hff)
                lol_count <= lol_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed and randomized bench for pll_lock_supervisor
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

    localparam int SS  = 2;
    localparam int PRC = 4;
    localparam int LSC = 8;
    localparam int LTC = 32;
    localparam int MR  = 3;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       lol_clr = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       fail;
    logic [7:0] lol_count;
    logic [7:0] retry_count;
    logic [2:0] state;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model: state plus "cycles remaining" in each timed phase
    int m_state, m_rst_left, m_wait_left, m_need, m_retry, m_lol;
    bit hist[$];

    always #10 refclk = ~refclk;

    pll_lock_supervisor #(
        .SYNC_STAGES(SS), .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
        .LOCK_TIMEOUT_CYCLES(LTC), .MAX_RETRIES(MR)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .lol_clr(lol_clr),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .fail(fail),
        .lol_count(lol_count), .retry_count(retry_count), .state(state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit lk;
        bit inc;
        if (!rst_n) begin
            m_state = 0; m_rst_left = PRC; m_retry = 0; m_lol = 0;
            hist.delete();
            for (int i = 0; i < SS; i++) hist.push_back(1'b0);
            return;
        end
        lk = hist[SS-1];
        hist.push_front(pll_locked);
        void'(hist.pop_back());
        inc = 1'b0;
        case (m_state)
            0: if (m_rst_left == 0) begin m_state = 1; m_wait_left = LTC; end
               else m_rst_left--;
            1: if (lk) begin m_state = 2; m_need = LSC; end
               else begin
                   m_wait_left--;
                   if (m_wait_left == 0) begin
                       m_retry++;
                       if (m_retry == MR) m_state = 4;
                       else begin m_state = 0; m_rst_left = PRC - 1; end
                   end
               end
            2: if (!lk) begin m_state = 1; m_wait_left = LTC; end
               else begin
                   m_need--;
                   if (m_need == 0) begin m_state = 3; m_retry = 0; end
               end
            3: if (!lk) begin m_state = 0; m_rst_left = PRC - 1; inc = 1'b1; end
            default: ;
        endcase
        if (lol_clr) m_lol = inc ? 1 : 0;
        else if (inc && m_lol < 255) m_lol++;
    endtask

    task automatic tick();
        @(posedge refclk);
        model_edge();
        cyc++;
        @(negedge refclk);
        check_eq("m_state", state, m_state);
        check_eq("m_pll_rst", pll_rst, (m_state == 0 || m_state == 4) ? 1 : 0);
        check_eq("m_sys_rst_n", sys_rst_n, (m_state == 3) ? 1 : 0);
        check_eq("m_fail", fail, (m_state == 4) ? 1 : 0);
        check_eq("m_retry", retry_count, m_retry);
        check_eq("m_lol", lol_count, m_lol);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check_eq("rst_state", state, 0);
        check_eq("rst_pll_rst", pll_rst, 1);
        check_eq("rst_sys_rst_n", sys_rst_n, 0);
        check_eq("rst_fail", fail, 0);
        check_eq("rst_retry", retry_count, 0);
        check_eq("rst_lol", lol_count, 0);
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 60 && !sys_rst_n; i++) tick();
        check_eq("wait_run", sys_rst_n, 1);
    endtask

    task automatic drop_event();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        // clean bring-up followed by a loss of lock in RUN
        pll_locked = 1'b1;
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            tick();
            if (cyc == 3)  check_eq("bu_pll_rst_c3", pll_rst, 1);
            if (cyc == 4)  begin check_eq("bu_pll_rst_c4", pll_rst, 0); check_eq("bu_wait_c4", state, 1); end
            if (cyc == 5)  check_eq("bu_stable_c5", state, 2);
            if (cyc == 12) check_eq("bu_sys_c12", sys_rst_n, 0);
            if (cyc == 13) begin check_eq("bu_sys_c13", sys_rst_n, 1); check_eq("bu_retry_c13", retry_count, 0); end
            if (cyc == 50) pll_locked = 1'b0;
            if (cyc == 52) check_eq("lol_sys_c52", sys_rst_n, 1);
            if (cyc == 53) begin
                check_eq("lol_sys_c53", sys_rst_n, 0);
                check_eq("lol_pll_rst_c53", pll_rst, 1);
                check_eq("lol_cnt_c53", lol_count, 1);
            end
            if (cyc == 56) begin check_eq("lol_pll_rst_c56", pll_rst, 1); pll_locked = 1'b1; end
            if (cyc == 57) check_eq("lol_pll_rst_c57", pll_rst, 0);
            if (cyc == 66) check_eq("rebu_sys_c66", sys_rst_n, 0);
            if (cyc == 67) check_eq("rebu_sys_c67", sys_rst_n, 1);
        end

        // short lock pulse while in WAIT_LOCK
        pll_locked = 1'b0;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            tick();
            if (cyc == 4)  pll_locked = 1'b1;
            if (cyc == 9)  pll_locked = 1'b0;
            if (cyc == 6)  check_eq("drop_wait_c6", state, 1);
            if (cyc == 7)  check_eq("drop_stable_c7", state, 2);
            if (cyc == 11) check_eq("drop_stable_c11", state, 2);
            if (cyc == 12) begin
                check_eq("drop_wait_c12", state, 1);
                check_eq("drop_pll_rst", pll_rst, 0);
                check_eq("drop_lol", lol_count, 0);
                check_eq("drop_retry", retry_count, 0);
            end
        end

        // repeated timeouts into FAIL
        pll_locked = 1'b0;
        do_reset();
        for (int c = 0; c <= 140; c++) begin
            tick();
            if (cyc == 35)  begin check_eq("to_state_c35", state, 1); check_eq("to_retry_c35", retry_count, 0); end
            if (cyc == 36)  begin check_eq("to_retry_c36", retry_count, 1); check_eq("to_pll_rst_c36", pll_rst, 1); end
            if (cyc == 72)  check_eq("to_retry_c72", retry_count, 2);
            if (cyc == 107) begin check_eq("to_fail_c107", fail, 0); check_eq("to_retry_c107", retry_count, 2); end
            if (cyc == 108) begin
                check_eq("to_fail_c108", fail, 1);
                check_eq("to_state_c108", state, 4);
                check_eq("to_retry_c108", retry_count, 3);
            end
            if (cyc == 110) pll_locked = 1'b1;
        end
        check_eq("fail_sticky_state", state, 4);
        check_eq("fail_sticky_pll_rst", pll_rst, 1);

        // lol_count saturation and clear interactions
        do_reset();
        for (int e = 0; e < 260; e++) begin
            wait_run();
            drop_event();
        end
        wait_run();
        check_eq("lol_sat", lol_count, 255);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        lol_clr = 1'b1;
        tick();
        lol_clr = 1'b0;
        check_eq("lol_clr_inc", lol_count, 1);
        wait_run();
        lol_clr = 1'b1;
        tick();
        lol_clr = 1'b0;
        check_eq("lol_clr_only", lol_count, 0);
        drop_event();
        wait_run();
        check_eq("lol_after_clr", lol_count, 1);

        // reset asserted mid-RUN
        check_eq("pre_rst_sys", sys_rst_n, 1);
        do_reset();

        // randomized lock patterns with occasional clears
        for (int r = 0; r < 6; r++) begin
            int seg_left;
            seg_left = 0;
            pll_locked = 1'($urandom_range(0, 1));
            do_reset();
            for (int n = 0; n < 500; n++) begin
                if (seg_left == 0) begin
                    pll_locked = ($urandom_range(0, 3) != 0);
                    seg_left = $urandom_range(1, 40);
                end
                seg_left--;
                lol_clr = ($urandom_range(0, 15) == 0);
                tick();
            end
            lol_clr = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
